mem_access_unit: RTL and testbench

//  Sequences load/store accesses between the multicycle control unit and the word-wide,

---
 rtl/ls_pkg.sv | 33 +++
 rtl/store_merge.sv | 25 ++
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 tb/tb_mem_access_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
// Load/store shared definitions: access-size codes (common to control unit,
// memory access unit and load-size extractor) plus the access FSM encoding.
// No ports; pure declarations and one alignment helper.
package ls_pkg;

  // Access size, same code as LS_control.
  typedef enum logic [1:0] {
    SIZE_NONE = 2'b00,
    SIZE_B    = 2'b01,
    SIZE_H    = 2'b10,
    SIZE_W    = 2'b11
  } ls_size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RD_WAIT = 2'b01,
    ST_WRITE   = 2'b10,
    ST_DONE    = 2'b11
  } mau_state_e;

  // Halfwords need an even address, words a 4-byte aligned one; bytes never fault.
  function automatic logic is_misaligned(input ls_size_e size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_H:  bad = addr_lo[0];
      SIZE_W:  bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Purpose: merges store data into the old memory word for SB/SH read-modify-write.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Ports: size_i access size, old_i word read from memory, wdata_i store data
//        (byte/half in low bits), merged_o word to write back.
module store_merge
  import ls_pkg::*;
(
  input  ls_size_e    size_i,
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    case (size_i)
      SIZE_B:  merged_o = {old_i[31:8], wdata_i[7:0]};
      SIZE_H:  merged_o = {old_i[31:16], wdata_i[15:0]};
      SIZE_W:  merged_o = wdata_i;
      // A zero-size merge leaves the word untouched.
      default: merged_o = old_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: sequences loads, word stores and byte/half read-modify-write stores
//          between the multicycle control unit and a word-wide byte-addressed memory.
// Latency: done after 1 (no-op/misaligned), 2 (SW), MEM_LATENCY+2 (load),
//          MEM_LATENCY+3 (SB/SH) cycles from the accept edge.
// Backpressure: req_ready only in IDLE; requests are ignored while busy and the
//          next one is accepted the cycle after done.
// Ports: clk/reset (async active-low); req_valid/req_ready/req_write/req_size/
//        req_addr/req_wdata from the control unit; mem_addr/mem_wr/mem_wdata/
//        mem_rdata to data memory; mdr_out raw loaded word; done/align_err status.
module mem_access_unit
  import ls_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mdr_out,
  output logic        done,
  output logic        align_err
);

  // The latency counter must be able to hold MEM_LATENCY without wrapping.
  if (MEM_LATENCY < 1 || MEM_LATENCY > (2 ** CNT_W) - 1) begin : g_bad_latency
    $error("mem_access_unit: MEM_LATENCY out of range for CNT_W");
  end

  mau_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  ls_size_e         size_q, size_d;
  logic             err_q, err_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             mem_wr_q, mem_wr_d;
  logic [31:0]      mdr_q, mdr_d;

  ls_size_e         req_size_e;
  logic             req_misal;
  logic [31:0]      merged;

  assign req_size_e = ls_size_e'(req_size);
  assign req_misal  = is_misaligned(req_size_e, req_addr[1:0]);

  // mem_wdata_q doubles as the store-data holding register during RD_WAIT:
  // mem_wr is low there, so its value is not visible to the memory.
  store_merge u_store_merge (
    .size_i   (size_q),
    .old_i    (mem_rdata),
    .wdata_i  (mem_wdata_q),
    .merged_o (merged)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    size_d      = size_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = 1'b0;
    mdr_d       = mdr_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d   = req_write;
          size_d = req_size_e;
          err_d  = req_misal;
          if (req_misal || req_size_e == SIZE_NONE) begin
            state_d = ST_DONE;
          end else begin
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
            if (req_write && req_size_e == SIZE_W) begin
              state_d  = ST_WRITE;
              mem_wr_d = 1'b1;
            end else begin
              state_d = ST_RD_WAIT;
              cnt_d   = CNT_W'(MEM_LATENCY);
            end
          end
        end
      end

      ST_RD_WAIT: begin
        // Counter reaches zero on edge A+MEM_LATENCY; the word is sampled one edge later.
        if (cnt_q == '0) begin
          if (wr_q) begin
            state_d     = ST_WRITE;
            mem_wr_d    = 1'b1;
            mem_wdata_d = merged;
          end else begin
            state_d = ST_DONE;
            mdr_d   = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      size_q      <= SIZE_NONE;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      mdr_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      mdr_q       <= mdr_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign align_err = done & err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign mdr_out   = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: instance 0 with MEM_LATENCY=1, instance 1 with
// MEM_LATENCY=3, each attached to a byte-address-keyed memory model whose read
// data is delayed by the instance's latency.
module tb_mem_access_unit;

  typedef struct {
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    string       name;
    int          lat;
    bit          err;
    logic [31:0] mdr;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    logic [31:0] init;
    req_t        req;
    exp_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [1:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] mem_addr  [2];
  logic        mem_wr    [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [31:0] mdr_out   [2];
  logic        done      [2];
  logic        align_err [2];

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_LATENCY(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .mem_addr(mem_addr[0]), .mem_wr(mem_wr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .mdr_out(mdr_out[0]), .done(done[0]), .align_err(align_err[0])
  );

  mem_access_unit #(.MEM_LATENCY(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .mem_addr(mem_addr[1]), .mem_wr(mem_wr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .mdr_out(mdr_out[1]), .done(done[1]), .align_err(align_err[1])
  );

  // Memory model: one 32-bit word per byte address (the word starting there).
  logic [31:0] mem [256];
  logic [31:0] pipe0;
  logic [31:0] pipe1 [3];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_dat;
  int          wr_cnt  [2] = '{0, 0};
  logic [31:0] last_wa [2];
  logic [31:0] last_wd [2];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_dat;
    pipe0    <= mem[mem_addr[0][7:0]];
    pipe1[0] <= mem[mem_addr[1][7:0]];
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
    for (int d = 0; d < 2; d++) begin
      if (mem_wr[d]) begin
        mem[mem_addr[d][7:0]] <= mem_wdata[d];
        wr_cnt[d]  <= wr_cnt[d] + 1;
        last_wa[d] <= mem_addr[d];
        last_wd[d] <= mem_wdata[d];
      end
    end
  end

  assign mem_rdata[0] = pipe0;
  assign mem_rdata[1] = pipe1[2];

  int   n_chk  = 0;
  int   n_fail = 0;
  int   ncyc   = 0;
  req_t pend_q [2][$];
  exp_t exp_q  [2][$];
  int   acc_q  [2][$];
  int   last_done [2] = '{0, 0};
  int   gap       [2] = '{0, 0};
  int   wr_base   [2] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic req_t mkreq(input bit wr, input logic [1:0] sz,
                                 input logic [31:0] a, input logic [31:0] wd);
    req_t r;
    r.wr = wr; r.size = sz; r.addr = a; r.wdata = wd;
    return r;
  endfunction

  function automatic exp_t mkexp(input string n, input int lat, input bit err,
                                 input logic [31:0] mdr, input int nwr,
                                 input logic [31:0] wa, input logic [31:0] wd);
    exp_t e;
    e.name = n; e.lat = lat; e.err = err; e.mdr = mdr;
    e.nwr = nwr; e.waddr = wa; e.wdata = wd;
    return e;
  endfunction

  task automatic check_done(input int d);
    exp_t e;
    int   a;
    if (exp_q[d].size() == 0 || acc_q[d].size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_done dut%0d: got done=1, expected no completion", d);
    end else begin
      e = exp_q[d].pop_front();
      a = acc_q[d].pop_front();
      chk({e.name, "_latency"}, ncyc - a, e.lat);
      chk({e.name, "_align_err"}, 32'(align_err[d]), 32'(e.err));
      chk({e.name, "_mdr"}, mdr_out[d], e.mdr);
      chk({e.name, "_nwrites"}, wr_cnt[d] - wr_base[d], e.nwr);
      if (e.nwr > 0) begin
        chk({e.name, "_waddr"}, last_wa[d], e.waddr);
        chk({e.name, "_wdata"}, last_wd[d], e.wdata);
      end
    end
    wr_base[d]   = wr_cnt[d];
    last_done[d] = ncyc;
  endtask

  // One cycle of the stimulus/monitor engine, evaluated at each falling edge.
  task automatic step();
    req_t r;
    @(negedge clk);
    ncyc++;
    for (int d = 0; d < 2; d++) begin
      if (done[d]) check_done(d);
      if (pend_q[d].size() > 0) begin
        r = pend_q[d][0];
        req_valid[d] = 1'b1;
        req_write[d] = r.wr;
        req_size[d]  = r.size;
        req_addr[d]  = r.addr;
        req_wdata[d] = r.wdata;
        // Ready is state-decoded, so it holds through the coming rising edge.
        if (req_ready[d]) begin
          acc_q[d].push_back(ncyc);
          gap[d] = ncyc - last_done[d];
          void'(pend_q[d].pop_front());
        end
      end else begin
        req_valid[d] = 1'b0;
      end
    end
  endtask

  task automatic enqueue(input int d, input req_t r, input exp_t e);
    pend_q[d].push_back(r);
    exp_q[d].push_back(e);
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] v);
    pre_we = 1'b1; pre_addr = a; pre_dat = v;
    step();
    pre_we = 1'b0;
  endtask

  task automatic drain(input int d, input int budget, input string name);
    int n;
    n = 0;
    while ((pend_q[d].size() > 0 || exp_q[d].size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk({name, "_outstanding"}, pend_q[d].size() + exp_q[d].size(), 0);
    pend_q[d].delete();
    exp_q[d].delete();
    acc_q[d].delete();
  endtask

  task automatic check_reset_state(input int d, input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready[d]), 32'(1));
    chk({tag, "_mem_wr"}, 32'(mem_wr[d]), 32'(0));
    chk({tag, "_done"}, 32'(done[d]), 32'(0));
    chk({tag, "_align_err"}, 32'(align_err[d]), 32'(0));
    chk({tag, "_mdr"}, mdr_out[d], 32'h0);
    chk({tag, "_mem_addr"}, mem_addr[d], 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata[d], 32'h0);
  endtask

  vec_t vecs[$];

  initial begin
    // init, request {wr,size,addr,wdata}, expected {lat,err,mdr,nwr,waddr,wdata}
    vecs.push_back('{32'hDEADBEEF, mkreq(0, 2'b11, 32'h10, 32'h0),
                     mkexp("lw_10", 3, 0, 32'hDEADBEEF, 0, 32'h0, 32'h0)});
    vecs.push_back('{32'h11223344, mkreq(1, 2'b01, 32'h21, 32'h000000AB),
                     mkexp("sb_21", 4, 0, 32'hDEADBEEF, 1, 32'h21, 32'h112233AB)});
    vecs.push_back('{32'hAAAABBBB, mkreq(1, 2'b10, 32'h22, 32'hFFFF5678),
                     mkexp("sh_22", 4, 0, 32'hDEADBEEF, 1, 32'h22, 32'hAAAA5678)});
    vecs.push_back('{32'h00000000, mkreq(1, 2'b11, 32'h30, 32'hCAFEF00D),
                     mkexp("sw_30", 2, 0, 32'hDEADBEEF, 1, 32'h30, 32'hCAFEF00D)});
    vecs.push_back('{32'h13131313, mkreq(1, 2'b10, 32'h13, 32'h00001234),
                     mkexp("sh_13_misal", 1, 1, 32'hDEADBEEF, 0, 32'h0, 32'h0)});
    vecs.push_back('{32'h12121212, mkreq(0, 2'b11, 32'h12, 32'h0),
                     mkexp("lw_12_misal", 1, 1, 32'hDEADBEEF, 0, 32'h0, 32'h0)});
    vecs.push_back('{32'h40404040, mkreq(0, 2'b00, 32'h40, 32'h0),
                     mkexp("ld_none", 1, 0, 32'hDEADBEEF, 0, 32'h0, 32'h0)});
    vecs.push_back('{32'h0A0B0C0D, mkreq(0, 2'b01, 32'h41, 32'h0),
                     mkexp("lb_41", 3, 0, 32'h0A0B0C0D, 0, 32'h0, 32'h0)});
    vecs.push_back('{32'h12345678, mkreq(0, 2'b10, 32'h46, 32'h0),
                     mkexp("lh_46", 3, 0, 32'h12345678, 0, 32'h0, 32'h0)});
    vecs.push_back('{32'h31313131, mkreq(1, 2'b11, 32'h31, 32'hFFFFFFFF),
                     mkexp("sw_31_misal", 1, 1, 32'h12345678, 0, 32'h0, 32'h0)});
    vecs.push_back('{32'h48484848, mkreq(1, 2'b00, 32'h48, 32'h77777777),
                     mkexp("st_none", 1, 0, 32'h12345678, 0, 32'h0, 32'h0)});

    rst_n  = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'b00;
      req_addr[d]  = '0;   req_wdata[d] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset_state(0, "reset_l1");
    check_reset_state(1, "reset_l3");
    rst_n = 1'b1;
    step();

    // Table-driven single accesses on the MEM_LATENCY=1 instance.
    foreach (vecs[i]) begin
      preload(vecs[i].req.addr[7:0], vecs[i].init);
      enqueue(0, vecs[i].req, vecs[i].exp);
      drain(0, 20, vecs[i].exp.name);
    end

    // MEM_LATENCY=3: two loads with req_valid held back-to-back, then an SB.
    preload(8'h60, 32'h01020304);
    preload(8'h64, 32'h0BADF00D);
    enqueue(1, mkreq(0, 2'b11, 32'h60, 32'h0), mkexp("l3_lw_60", 5, 0, 32'h01020304, 0, 32'h0, 32'h0));
    enqueue(1, mkreq(0, 2'b11, 32'h64, 32'h0), mkexp("l3_lw_64", 5, 0, 32'h0BADF00D, 0, 32'h0, 32'h0));
    drain(1, 40, "l3_b2b");
    chk("l3_b2b_accept_after_done", gap[1], 1);
    preload(8'h70, 32'hA1A2A3A4);
    enqueue(1, mkreq(1, 2'b01, 32'h70, 32'h0000005B), mkexp("l3_sb_70", 6, 0, 32'h0BADF00D, 1, 32'h70, 32'hA1A2A35B));
    drain(1, 40, "l3_sb");

    // Reset asserted during the write cycle of an SB: the write must not land.
    begin
      int n;
      preload(8'h50, 32'h55667788);
      enqueue(0, mkreq(1, 2'b01, 32'h50, 32'h00000099), mkexp("sb_50_aborted", 0, 0, 32'h0, 0, 32'h0, 32'h0));
      n = 0;
      while (mem_wr[0] !== 1'b1 && n < 10) begin
        step();
        n++;
      end
      chk("rst_reached_write", 32'(mem_wr[0]), 32'(1));
      rst_n = 1'b0;
      #1;
      check_reset_state(0, "rst_mid_write");
      pend_q[0].delete();
      exp_q[0].delete();
      acc_q[0].delete();
      step();
      rst_n = 1'b1;
      wr_base[0] = wr_cnt[0];
      enqueue(0, mkreq(0, 2'b11, 32'h50, 32'h0), mkexp("lw_50_after_rst", 3, 0, 32'h55667788, 0, 32'h0, 32'h0));
      drain(0, 20, "after_rst");
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
